// File: rtl/pcie_pkg.sv
// Shared definitions for the PCIe transaction-layer egress path:
// flow-control state encoding, VC identifiers and default sizing.
package pcie_pkg;

  typedef enum logic {
    FLOWING = 1'b0,
    PAUSED  = 1'b1
  } flow_state_t;

  localparam logic VC0 = 1'b0;
  localparam logic VC1 = 1'b1;

  localparam int ADDR_WIDTH_DEF = 3;
  localparam int MAX_BURST_DEF  = 4;

endpackage

// File: rtl/vc_flow_fsm.sv
// Per-VC hysteresis FSM: pauses a VC when occupancy reaches umbralA and
// resumes it once occupancy falls to umbralB; freeze suspends all transitions.
module vc_flow_fsm
  import pcie_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count,
  input  logic [3:0]       umbralA,
  input  logic [3:0]       umbralB,
  input  logic             freeze,
  output logic             pause,
  output logic             cont,
  output logic             paused
);

  // Compare at a width that holds both the occupancy and the 4-bit thresholds.
  localparam int CMP_W = (CNT_W > 4) ? CNT_W : 4;

  logic [CMP_W-1:0] cnt_x, a_x, b_x;
  flow_state_t      state_q, state_d;
  logic             pause_d, cont_d;

  assign cnt_x = CMP_W'(count);
  assign a_x   = CMP_W'(umbralA);
  assign b_x   = CMP_W'(umbralB);

  always_comb begin
    state_d = state_q;
    pause_d = 1'b0;
    cont_d  = 1'b0;
    if (!freeze) begin
      case (state_q)
        FLOWING: if (cnt_x >= a_x) begin
          state_d = PAUSED;
          pause_d = 1'b1;
        end
        PAUSED: if (cnt_x <= b_x) begin
          state_d = FLOWING;
          cont_d  = 1'b1;
        end
        default: state_d = FLOWING;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FLOWING;
      pause   <= 1'b0;
      cont    <= 1'b0;
    end else begin
      state_q <= state_d;
      pause   <= pause_d;
      cont    <= cont_d;
    end
  end

  assign paused = (state_q == PAUSED);

endmodule

// File: rtl/vc_egress_scheduler.sv
// Egress scheduler for one port: VC0-priority pop arbitration with a VC1
// starvation guard, registered egress valid/vc_id, and per-VC flow control.
module vc_egress_scheduler
  import pcie_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty_vc0,
  input  logic                  empty_vc1,
  input  logic [ADDR_WIDTH:0]   count_vc0,
  input  logic [ADDR_WIDTH:0]   count_vc1,
  input  logic                  out_ready,
  input  logic [3:0]            umbralA,
  input  logic [3:0]            umbralB,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic                  valid_out,
  output logic                  vc_id,
  output logic                  pause_vc0,
  output logic                  pause_vc1,
  output logic                  continue_vc0,
  output logic                  continue_vc1,
  output logic                  paused_vc0,
  output logic                  paused_vc1,
  output logic                  cfg_err
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  logic [3:0] burst_cnt;
  logic       starve;
  logic       cfg_bad;
  logic       vld_p1;
  logic       vc_id_p1;

  // Stage p0: combinational grant from FIFO status and burst history
  assign starve  = (burst_cnt == BURST_MAX) & ~empty_vc1;
  assign pop_vc0 = ~reset & out_ready & ~empty_vc0 & ~starve;
  assign pop_vc1 = ~reset & out_ready & ~empty_vc1 & ~pop_vc0;

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (empty_vc1 || pop_vc1) begin
      burst_cnt <= '0;
    end else if (pop_vc0 && (burst_cnt != BURST_MAX)) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end

  // Stage p1: FIFO data arrives one cycle after the pop
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      vc_id_p1 <= VC0;
    end else begin
      vld_p1 <= pop_vc0 | pop_vc1;
      if (pop_vc0 || pop_vc1)
        vc_id_p1 <= pop_vc1 ? VC1 : VC0;
    end
  end

  assign valid_out = vld_p1;
  assign vc_id     = vc_id_p1;

  // Inverted thresholds leave no hysteresis band, so flow control holds still.
  assign cfg_bad = (umbralB >= umbralA);

  always_ff @(posedge clk) begin
    if (reset) cfg_err <= 1'b0;
    else       cfg_err <= cfg_bad;
  end

  vc_flow_fsm #(.CNT_W(ADDR_WIDTH + 1)) u_flow_vc0 (
    .clk     (clk),
    .reset   (reset),
    .count   (count_vc0),
    .umbralA (umbralA),
    .umbralB (umbralB),
    .freeze  (cfg_bad),
    .pause   (pause_vc0),
    .cont    (continue_vc0),
    .paused  (paused_vc0)
  );

  vc_flow_fsm #(.CNT_W(ADDR_WIDTH + 1)) u_flow_vc1 (
    .clk     (clk),
    .reset   (reset),
    .count   (count_vc1),
    .umbralA (umbralA),
    .umbralB (umbralB),
    .freeze  (cfg_bad),
    .pause   (pause_vc1),
    .cont    (continue_vc1),
    .paused  (paused_vc1)
  );

endmodule
